// File: rtl/reg_file_rename_pkg.sv
// Shared constants for the rename-aware architectural register file.
// Widths, null tags and small helpers used by the top and its read ports.
package reg_file_rename_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int REG_TAG_WIDTH = 5;
    localparam int ROB_TAG_WIDTH = 4;
    localparam int REG_COUNT     = 32;

    localparam logic [ROB_TAG_WIDTH-1:0] ZERO_TAG_ROB = '0;
    localparam logic [REG_TAG_WIDTH-1:0] ZERO_TAG_REG = '0;
    localparam logic [DATA_WIDTH-1:0]    ZERO_DATA    = '0;
    localparam logic                     TRUE         = 1'b1;
    localparam logic                     FALSE        = 1'b0;

    // Register index 0 means "no operation" on the rename and commit interfaces.
    function automatic logic reg_valid(input logic [REG_TAG_WIDTH-1:0] idx);
        return idx != ZERO_TAG_REG;
    endfunction

endpackage

// File: rtl/reg_file_rename_read_port.sv
// Single combinational operand lookup with same-cycle commit bypass.
// The top supplies the stored entry for idx_i; this block decides what the decoder sees.
module reg_read_port
    import reg_file_rename_pkg::*;
#(
    parameter int DATA_W    = DATA_WIDTH,
    parameter int ROB_TAG_W = ROB_TAG_WIDTH
) (
    input  logic [REG_TAG_WIDTH-1:0] idx_i,
    input  logic [DATA_W-1:0]        reg_value_i,
    input  logic                     reg_busy_i,
    input  logic [ROB_TAG_W-1:0]     reg_tag_i,
    input  logic [REG_TAG_WIDTH-1:0] commit_reg_i,
    input  logic [ROB_TAG_W-1:0]     commit_tag_i,
    input  logic [DATA_W-1:0]        commit_value_i,
    output logic [DATA_W-1:0]        value_o,
    output logic [ROB_TAG_W-1:0]     robtag_o,
    output logic                     busy_o
);

    logic bypass;

    assign bypass = reg_valid(commit_reg_i) && (commit_reg_i == idx_i)
                    && reg_busy_i && (commit_tag_i == reg_tag_i);

    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        value_o  = reg_value_i;
        robtag_o = reg_busy_i ? reg_tag_i : '0;
        busy_o   = reg_busy_i;
        if (bypass) begin
            value_o  = commit_value_i;
            robtag_o = '0;
            busy_o   = FALSE;
        end
    end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register busy bit and owning ROB tag.
// Two combinational operand queries; rename, commit and flush update on the clock edge.
module reg_file_rename
    import reg_file_rename_pkg::*;
#(
    parameter int DATA_W    = DATA_WIDTH,
    parameter int REG_NUM   = REG_COUNT,
    parameter int ROB_TAG_W = ROB_TAG_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic [REG_TAG_WIDTH-1:0] in_dec_tag1,
    output logic [DATA_W-1:0]        out_dec_value1,
    output logic [ROB_TAG_W-1:0]     out_dec_robtag1,
    output logic                     out_dec_busy1,
    input  logic [REG_TAG_WIDTH-1:0] in_dec_tag2,
    output logic [DATA_W-1:0]        out_dec_value2,
    output logic [ROB_TAG_W-1:0]     out_dec_robtag2,
    output logic                     out_dec_busy2,
    input  logic [REG_TAG_WIDTH-1:0] in_dec_dest,
    input  logic [ROB_TAG_W-1:0]     in_dec_rob_tag,
    input  logic [REG_TAG_WIDTH-1:0] in_rob_commit_reg,
    input  logic [ROB_TAG_W-1:0]     in_rob_commit_tag,
    input  logic [DATA_W-1:0]        in_rob_commit_value,
    input  logic                     in_rob_clear
);

    logic [DATA_W-1:0]    value_q [REG_NUM];
    logic [DATA_W-1:0]    value_d [REG_NUM];
    logic [REG_NUM-1:0]   busy_q, busy_d;
    logic [ROB_TAG_W-1:0] tag_q [REG_NUM];
    logic [ROB_TAG_W-1:0] tag_d [REG_NUM];

    logic commit_valid, rename_valid, rename_hits_commit;

    assign commit_valid       = reg_valid(in_rob_commit_reg);
    assign rename_valid       = reg_valid(in_dec_dest) && !in_rob_clear;
    assign rename_hits_commit = rename_valid && (in_dec_dest == in_rob_commit_reg);

    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;

        // Commit writes are in order, so the value lands even if a newer rename owns the register.
        if (commit_valid) begin
            value_d[in_rob_commit_reg] = in_rob_commit_value;
            if (tag_q[in_rob_commit_reg] == in_rob_commit_tag && !rename_hits_commit)
                busy_d[in_rob_commit_reg] = FALSE;
        end

        if (in_rob_clear) begin
            busy_d = '0;
            for (int i = 0; i < REG_NUM; i++) tag_d[i] = ZERO_TAG_ROB;
        end else if (rename_valid) begin
            busy_d[in_dec_dest] = TRUE;
            tag_d[in_dec_dest]  = in_dec_rob_tag;
        end

        value_d[0] = '0;
        busy_d[0]  = FALSE;
        tag_d[0]   = ZERO_TAG_ROB;
    end

    // NOTE: the register array is reset explicitly because every entry must read zero after rst;
    // all sequential state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '{default: '0};
            busy_q  <= '0;
            tag_q   <= '{default: '0};
        end else if (rdy) begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    reg_read_port #(.DATA_W(DATA_W), .ROB_TAG_W(ROB_TAG_W)) u_port1 (
        .idx_i          (in_dec_tag1),
        .reg_value_i    (value_q[in_dec_tag1]),
        .reg_busy_i     (busy_q[in_dec_tag1]),
        .reg_tag_i      (tag_q[in_dec_tag1]),
        .commit_reg_i   (in_rob_commit_reg),
        .commit_tag_i   (in_rob_commit_tag),
        .commit_value_i (in_rob_commit_value),
        .value_o        (out_dec_value1),
        .robtag_o       (out_dec_robtag1),
        .busy_o         (out_dec_busy1)
    );

    reg_read_port #(.DATA_W(DATA_W), .ROB_TAG_W(ROB_TAG_W)) u_port2 (
        .idx_i          (in_dec_tag2),
        .reg_value_i    (value_q[in_dec_tag2]),
        .reg_busy_i     (busy_q[in_dec_tag2]),
        .reg_tag_i      (tag_q[in_dec_tag2]),
        .commit_reg_i   (in_rob_commit_reg),
        .commit_tag_i   (in_rob_commit_tag),
        .commit_value_i (in_rob_commit_value),
        .value_o        (out_dec_value2),
        .robtag_o       (out_dec_robtag2),
        .busy_o         (out_dec_busy2)
    );

endmodule

// File: tb/tb_reg_file_rename.sv
// Self-checking bench for reg_file_rename: directed scenarios plus a randomized run
// compared against an array-based reference model of the register file.
module tb_reg_file_rename;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [4:0]  in_dec_tag1, in_dec_tag2, in_dec_dest, in_rob_commit_reg;
    logic [3:0]  in_dec_rob_tag, in_rob_commit_tag;
    logic [31:0] in_rob_commit_value;
    logic        in_rob_clear;
    logic [31:0] out_dec_value1, out_dec_value2;
    logic [3:0]  out_dec_robtag1, out_dec_robtag2;
    logic        out_dec_busy1, out_dec_busy2;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_val [32];
    logic        m_busy [32];
    logic [3:0]  m_tag [32];

    // Port observation packed as {busy, robtag, value}
    logic [36:0] p1, p2;
    assign p1 = {out_dec_busy1, out_dec_robtag1, out_dec_value1};
    assign p2 = {out_dec_busy2, out_dec_robtag2, out_dec_value2};

    always #5 clk = ~clk;

    reg_file_rename dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .in_dec_tag1         (in_dec_tag1),
        .out_dec_value1      (out_dec_value1),
        .out_dec_robtag1     (out_dec_robtag1),
        .out_dec_busy1       (out_dec_busy1),
        .in_dec_tag2         (in_dec_tag2),
        .out_dec_value2      (out_dec_value2),
        .out_dec_robtag2     (out_dec_robtag2),
        .out_dec_busy2       (out_dec_busy2),
        .in_dec_dest         (in_dec_dest),
        .in_dec_rob_tag      (in_dec_rob_tag),
        .in_rob_commit_reg   (in_rob_commit_reg),
        .in_rob_commit_tag   (in_rob_commit_tag),
        .in_rob_commit_value (in_rob_commit_value),
        .in_rob_clear        (in_rob_clear)
    );

    // Expected query answer for register r under the current inputs.
    function automatic logic [36:0] model_query(input logic [4:0] r);
        if (in_rob_commit_reg != 0 && in_rob_commit_reg == r && m_busy[r]
            && in_rob_commit_tag == m_tag[r])
            return {1'b0, 4'd0, in_rob_commit_value};
        return {m_busy[r], (m_busy[r] ? m_tag[r] : 4'd0), m_val[r]};
    endfunction

    // Apply the architectural update rules for one clock edge.
    function automatic void model_update();
        logic [4:0] cr;
        logic       same_rename;
        cr = in_rob_commit_reg;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
            return;
        end
        if (!rdy) return;
        same_rename = !in_rob_clear && in_dec_dest != 0 && in_dec_dest == cr;
        if (cr != 0) begin
            m_val[cr] = in_rob_commit_value;
            if (m_tag[cr] == in_rob_commit_tag && !same_rename) m_busy[cr] = 1'b0;
        end
        if (in_rob_clear) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (in_dec_dest != 0) begin
            m_busy[in_dec_dest] = 1'b1;
            m_tag[in_dec_dest]  = in_dec_rob_tag;
        end
    endfunction

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; in_rob_clear = 1'b0;
        in_dec_dest = '0; in_dec_rob_tag = '0;
        in_rob_commit_reg = '0; in_rob_commit_tag = '0; in_rob_commit_value = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; in_dec_tag1 = 5'd5; in_dec_tag2 = 5'd0;
        step();
        idle();
        @(negedge clk);
        vectors++;
        if (p1 !== 37'h0) begin miscompares++; $display("FAIL reset_x5 got %h want %h", p1, 37'h0); end
        vectors++;
        if (p2 !== 37'h0) begin miscompares++; $display("FAIL reset_x0 got %h want %h", p2, 37'h0); end
        in_rob_commit_reg = 5'd0; in_rob_commit_value = 32'hDEAD;
        step();
        idle();
        @(negedge clk);
        vectors++;
        if (p2 !== 37'h0) begin miscompares++; $display("FAIL x0_write got %h want %h", p2, 37'h0); end
    endtask

    task automatic test_rename_commit();
        idle(); in_dec_dest = 5'd3; in_dec_rob_tag = 4'd2;
        step();
        idle(); in_dec_tag1 = 5'd3;
        @(negedge clk);
        vectors++;
        if (p1 !== {1'b1, 4'd2, 32'h0}) begin
            miscompares++; $display("FAIL rename_x3 got %h want %h", p1, {1'b1, 4'd2, 32'h0});
        end
        in_rob_commit_reg = 5'd3; in_rob_commit_tag = 4'd2; in_rob_commit_value = 32'h1234;
        #1;
        vectors++;
        if (p1 !== {1'b0, 4'd0, 32'h1234}) begin
            miscompares++; $display("FAIL bypass_x3 got %h want %h", p1, {1'b0, 4'd0, 32'h1234});
        end
        step();
        idle();
        @(negedge clk);
        vectors++;
        if (p1 !== {1'b0, 4'd0, 32'h1234}) begin
            miscompares++; $display("FAIL commit_x3 got %h want %h", p1, {1'b0, 4'd0, 32'h1234});
        end
    endtask

    task automatic test_stale_commit();
        idle(); in_dec_dest = 5'd4; in_dec_rob_tag = 4'd1; step();
        idle(); in_dec_dest = 5'd4; in_dec_rob_tag = 4'd3; step();
        idle(); in_rob_commit_reg = 5'd4; in_rob_commit_tag = 4'd1; in_rob_commit_value = 32'd7; step();
        idle(); in_dec_tag1 = 5'd4;
        @(negedge clk);
        vectors++;
        if (p1 !== {1'b1, 4'd3, 32'd7}) begin
            miscompares++; $display("FAIL stale_x4 got %h want %h", p1, {1'b1, 4'd3, 32'd7});
        end
        in_rob_commit_reg = 5'd4; in_rob_commit_tag = 4'd3; in_rob_commit_value = 32'd9; step();
        idle();
        @(negedge clk);
        vectors++;
        if (p1 !== {1'b0, 4'd0, 32'd9}) begin
            miscompares++; $display("FAIL owner_x4 got %h want %h", p1, {1'b0, 4'd0, 32'd9});
        end
    endtask

    task automatic test_commit_rename_same();
        idle();
        in_rob_commit_reg = 5'd6; in_rob_commit_tag = 4'd5; in_rob_commit_value = 32'hAA;
        in_dec_dest = 5'd6; in_dec_rob_tag = 4'd6;
        step();
        idle(); in_dec_tag2 = 5'd6;
        @(negedge clk);
        vectors++;
        if (p2 !== {1'b1, 4'd6, 32'hAA}) begin
            miscompares++; $display("FAIL same_x6 got %h want %h", p2, {1'b1, 4'd6, 32'hAA});
        end
    endtask

    task automatic test_clear();
        logic [4:0] regs [4];
        idle(); in_dec_dest = 5'd1; in_dec_rob_tag = 4'd1; step();
        idle(); in_dec_dest = 5'd2; in_dec_rob_tag = 4'd2; step();
        idle(); in_dec_dest = 5'd7; in_dec_rob_tag = 4'd4; step();
        idle(); in_rob_clear = 1'b1; in_dec_dest = 5'd8; in_dec_rob_tag = 4'd5;
        in_rob_commit_reg = 5'd1; in_rob_commit_tag = 4'd1; in_rob_commit_value = 32'h55;
        step();
        idle(); in_dec_tag1 = 5'd1; in_dec_tag2 = 5'd8;
        @(negedge clk);
        vectors++;
        if (p1 !== {1'b0, 4'd0, 32'h55}) begin
            miscompares++; $display("FAIL clear_x1 got %h want %h", p1, {1'b0, 4'd0, 32'h55});
        end
        vectors++;
        if (p2 !== 37'h0) begin miscompares++; $display("FAIL clear_x8 got %h want %h", p2, 37'h0); end
        regs = '{5'd2, 5'd7, 5'd3, 5'd4};
        for (int i = 0; i < 4; i++) begin
            in_dec_tag1 = regs[i];
            #1;
            vectors++;
            if (out_dec_busy1 !== 1'b0 || out_dec_robtag1 !== 4'd0) begin
                miscompares++;
                $display("FAIL clear_busy x%0d got busy=%b tag=%0d want 0/0", regs[i], out_dec_busy1, out_dec_robtag1);
            end
        end
    endtask

    task automatic test_rdy_hold();
        idle(); rdy = 1'b0; in_dec_dest = 5'd9; in_dec_rob_tag = 4'd7;
        in_rob_commit_reg = 5'd3; in_rob_commit_tag = 4'd0; in_rob_commit_value = 32'h99;
        in_dec_tag1 = 5'd9; in_dec_tag2 = 5'd3;
        step();
        @(negedge clk);
        vectors++;
        if (p1 !== 37'h0) begin miscompares++; $display("FAIL hold_x9 got %h want %h", p1, 37'h0); end
        vectors++;
        if (p2 !== {1'b0, 4'd0, 32'h1234}) begin
            miscompares++; $display("FAIL hold_x3 got %h want %h", p2, {1'b0, 4'd0, 32'h1234});
        end
        rdy = 1'b1;
        step();
        idle();
        @(negedge clk);
        vectors++;
        if (p1 !== {1'b1, 4'd7, 32'h0}) begin
            miscompares++; $display("FAIL release_x9 got %h want %h", p1, {1'b1, 4'd7, 32'h0});
        end
        vectors++;
        if (p2 !== {1'b0, 4'd0, 32'h99}) begin
            miscompares++; $display("FAIL release_x3 got %h want %h", p2, {1'b0, 4'd0, 32'h99});
        end
    endtask

    task automatic test_random();
        logic [36:0] exp1, exp2;
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            rdy          = ($urandom_range(0, 7) != 0);
            in_rob_clear = ($urandom_range(0, 19) == 0);
            in_dec_dest  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            in_dec_rob_tag    = 4'($urandom_range(0, 15));
            in_rob_commit_reg = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            in_rob_commit_tag = ($urandom_range(0, 1) == 0) ? m_tag[in_rob_commit_reg]
                                                             : 4'($urandom_range(0, 15));
            in_rob_commit_value = $urandom;
            in_dec_tag1 = ($urandom_range(0, 3) == 0) ? in_rob_commit_reg : 5'($urandom_range(0, 31));
            in_dec_tag2 = 5'($urandom_range(0, 31));
            @(negedge clk);
            exp1 = model_query(in_dec_tag1);
            exp2 = model_query(in_dec_tag2);
            vectors++;
            if (p1 !== exp1) begin
                miscompares++; $display("FAIL rand%0d port1 x%0d got %h want %h", n, in_dec_tag1, p1, exp1);
            end
            vectors++;
            if (p2 !== exp2) begin
                miscompares++; $display("FAIL rand%0d port2 x%0d got %h want %h", n, in_dec_tag2, p2, exp2);
            end
            step();
        end
    endtask

    initial begin
        idle();
        in_dec_tag1 = '0; in_dec_tag2 = '0;
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_commit_rename_same();
        test_clear();
        test_rdy_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
